// File: rtl/enclave_op_dispatcher.sv
// enclave_op_dispatcher
//   Host-side command issuer for the encrypt/decrypt/add/mult sequencing
//   controller. Host commands are queued in a small FIFO and issued one at a
//   time: each issue registers the command fields onto the ctrl_* outputs and
//   raises ctrl_config_en for one cycle. The block then waits for ctrl_done or
//   a timeout and returns a tagged response that reports the BUSY cycle count.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cmd_*               host command (valid/ready handshake) into the FIFO
//   ctrl_*              configuration interface of the controller, plus its done flag
//   rsp_*               response to the host (valid/ready handshake)
//   busy                FSM is not in IDLE
//   fifo_count          registered FIFO occupancy
module enclave_op_dispatcher #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BIG_N          = 30,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FIFO_AW        = 2,
  parameter int unsigned CYC_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  input  logic [BIG_N-1:0]      cmd_noise,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  ctrl_config_en,
  output logic [1:0]            ctrl_opcode,
  output logic [ADDR_WIDTH-1:0] ctrl_op1_base_addr,
  output logic [ADDR_WIDTH-1:0] ctrl_op2_base_addr,
  output logic [ADDR_WIDTH-1:0] ctrl_out_base_addr,
  output logic [BIG_N-1:0]      ctrl_noise,
  input  logic                  ctrl_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_timeout,
  output logic [CYC_WIDTH-1:0]  rsp_cycles,
  output logic                  busy,
  output logic [FIFO_AW:0]      fifo_count
);

  localparam logic [FIFO_AW:0]     FULL_COUNT  = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [CYC_WIDTH-1:0] TIMEOUT_VAL = CYC_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RETIRE
  } state_t;

  typedef struct packed {
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] op1;
    logic [ADDR_WIDTH-1:0] op2;
    logic [ADDR_WIDTH-1:0] out;
    logic [BIG_N-1:0]      noise;
    logic [TAG_WIDTH-1:0]  tag;
  } cmd_t;

  state_t               state, state_next;
  cmd_t                 mem [FIFO_DEPTH];
  cmd_t                 head;
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 push, pop;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CYC_WIDTH-1:0] cyc_cnt, cyc_inc;
  logic                 timeout_hit;

  assign cmd_ready  = (count != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // Counter value including the current BUSY cycle, saturating at all-ones.
  assign cyc_inc     = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
  assign timeout_hit = (cyc_inc >= TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: cmd_opcode, op1: cmd_op1_addr, op2: cmd_op2_addr,
                       out: cmd_out_addr, noise: cmd_noise, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      ctrl_opcode        <= '0;
      ctrl_op1_base_addr <= '0;
      ctrl_op2_base_addr <= '0;
      ctrl_out_base_addr <= '0;
      ctrl_noise         <= '0;
      tag_q              <= '0;
      cyc_cnt            <= '0;
      rsp_tag            <= '0;
      rsp_timeout        <= 1'b0;
      rsp_cycles         <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        ctrl_opcode        <= head.opcode;
        ctrl_op1_base_addr <= head.op1;
        ctrl_op2_base_addr <= head.op2;
        ctrl_out_base_addr <= head.out;
        ctrl_noise         <= head.noise;
        tag_q              <= head.tag;
        cyc_cnt            <= '0;
      end
      if (state == BUSY) begin
        cyc_cnt <= cyc_inc;
        // Done takes priority over a timeout landing in the same cycle.
        if (ctrl_done) begin
          rsp_tag     <= tag_q;
          rsp_timeout <= 1'b0;
          rsp_cycles  <= cyc_inc;
        end else if (timeout_hit) begin
          rsp_tag     <= tag_q;
          rsp_timeout <= 1'b1;
          rsp_cycles  <= TIMEOUT_VAL;
        end
      end
    end
  end

  always_comb begin
    state_next     = state;
    ctrl_config_en = 1'b0;
    rsp_valid      = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE:   if (count != '0) state_next = ISSUE;
      ISSUE: begin
        ctrl_config_en = 1'b1;
        state_next     = BUSY;
      end
      // ctrl_done is only looked at here, so a stale level cannot retire a new op.
      BUSY:   if (ctrl_done || timeout_hit) state_next = RETIRE;
      RETIRE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enclave_op_dispatcher.sv
// tb_enclave_op_dispatcher
//   Directed bench for enclave_op_dispatcher with TIMEOUT_CYCLES=20. Inputs
//   are driven and outputs sampled 1 time unit after each rising edge.
module tb_enclave_op_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [9:0]  cmd_op1_addr, cmd_op2_addr, cmd_out_addr;
  logic [29:0] cmd_noise;
  logic [3:0]  cmd_tag;
  logic        ctrl_config_en;
  logic [1:0]  ctrl_opcode;
  logic [9:0]  ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr;
  logic [29:0] ctrl_noise;
  logic        ctrl_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_tag;
  logic        rsp_timeout;
  logic [11:0] rsp_cycles;
  logic        busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  enclave_op_dispatcher #(
    .ADDR_WIDTH(10), .BIG_N(30), .TAG_WIDTH(4), .FIFO_DEPTH(4), .FIFO_AW(2),
    .CYC_WIDTH(12), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1_addr(cmd_op1_addr), .cmd_op2_addr(cmd_op2_addr), .cmd_out_addr(cmd_out_addr),
    .cmd_noise(cmd_noise), .cmd_tag(cmd_tag),
    .ctrl_config_en(ctrl_config_en), .ctrl_opcode(ctrl_opcode),
    .ctrl_op1_base_addr(ctrl_op1_base_addr), .ctrl_op2_base_addr(ctrl_op2_base_addr),
    .ctrl_out_base_addr(ctrl_out_base_addr), .ctrl_noise(ctrl_noise),
    .ctrl_done(ctrl_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and holds it until accepted (bounded).
  task automatic push(input logic [1:0] op, input logic [9:0] a1, input logic [9:0] a2,
                      input logic [9:0] ao, input logic [29:0] nz, input logic [3:0] tg);
    int n;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1_addr = a1; cmd_op2_addr = a2;
    cmd_out_addr = ao; cmd_noise = nz; cmd_tag = tg;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("push_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cfg();
    int n;
    n = 0;
    while (!ctrl_config_en && n < 100) begin
      tick();
      n++;
    end
    check("cfg_seen", 64'(ctrl_config_en), 64'd1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int n;
    logic seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1_addr = '0; cmd_op2_addr = '0;
    cmd_out_addr = '0; cmd_noise = '0; cmd_tag = '0; ctrl_done = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready",  64'(cmd_ready), 64'd1);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_rsp_valid",  64'(rsp_valid), 64'd0);
    check("rst_config_en",  64'(ctrl_config_en), 64'd0);
    check("rst_ctrl_fields", 64'({ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr,
                                  ctrl_out_base_addr}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_tag, rsp_timeout, rsp_cycles}), 64'd0);

    // Single encrypt with done 12 cycles after config_en
    push(2'b00, 10'h010, 10'h040, 10'h100, 30'h2AAA5555, 4'd3);
    check("t1_count_c1", 64'(fifo_count), 64'd1);
    check("t1_cfg_c1",   64'(ctrl_config_en), 64'd0);
    check("t1_busy_c1",  64'(busy), 64'd0);
    tick();
    check("t1_cfg_c2",   64'(ctrl_config_en), 64'd1);
    check("t1_opcode",   64'(ctrl_opcode), 64'd0);
    check("t1_op1",      64'(ctrl_op1_base_addr), 64'h010);
    check("t1_op2",      64'(ctrl_op2_base_addr), 64'h040);
    check("t1_out",      64'(ctrl_out_base_addr), 64'h100);
    check("t1_noise",    64'(ctrl_noise), 64'h2AAA5555);
    check("t1_busy_c2",  64'(busy), 64'd1);
    check("t1_count_c2", 64'(fifo_count), 64'd0);
    pulses = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(ctrl_config_en);
    end
    check("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    ctrl_done = 1'b1;
    tick();
    pulses += int'(ctrl_config_en);
    check("t1_pulses",   64'(pulses), 64'd1);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_tag",  64'(rsp_tag), 64'd3);
    check("t1_rsp_to",   64'(rsp_timeout), 64'd0);
    check("t1_rsp_cyc",  64'(rsp_cycles), 64'd12);
    ctrl_done = 1'b0;
    ack();
    check("t1_rsp_drop", 64'(rsp_valid), 64'd0);
    check("t1_idle",     64'(busy), 64'd0);

    // Stale done: high in IDLE with empty FIFO, then held across ISSUE
    ctrl_done = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | rsp_valid | busy;
    end
    check("stale_idle_quiet", 64'(seen), 64'd0);
    push(2'b01, 10'h001, 10'h002, 10'h003, 30'h1, 4'd7);
    tick();
    check("stale_issue", 64'(ctrl_config_en), 64'd1);
    tick();
    check("stale_no_rsp_busy", 64'(rsp_valid), 64'd0);
    tick();
    check("stale_rsp_valid", 64'(rsp_valid), 64'd1);
    check("stale_rsp_cyc",   64'(rsp_cycles), 64'd1);
    check("stale_rsp_tag",   64'(rsp_tag), 64'd7);
    ctrl_done = 1'b0;
    ack();

    // Timeout after 20 BUSY cycles
    push(2'b01, 10'h0AA, 10'h0BB, 10'h0CC, 30'h3, 4'd9);
    wait_cfg();
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", 64'(n), 64'd21);
    check("to_flag",    64'(rsp_timeout), 64'd1);
    check("to_cycles",  64'(rsp_cycles), 64'd20);
    check("to_tag",     64'(rsp_tag), 64'd9);
    ack();

    // Done and timeout in the same cycle: done wins
    push(2'b10, 10'h005, 10'h006, 10'h007, 30'h4, 4'd10);
    wait_cfg();
    repeat (20) tick();
    check("both_not_yet", 64'(rsp_valid), 64'd0);
    ctrl_done = 1'b1;
    tick();
    check("both_valid",  64'(rsp_valid), 64'd1);
    check("both_flag",   64'(rsp_timeout), 64'd0);
    check("both_cycles", 64'(rsp_cycles), 64'd20);
    check("both_tag",    64'(rsp_tag), 64'd10);
    ctrl_done = 1'b0;
    ack();

    // Back-pressure on the response with a second command queued
    push(2'b10, 10'h011, 10'h012, 10'h013, 30'h5, 4'd11);
    push(2'b11, 10'h222, 10'h333, 10'h3FF, 30'h6, 4'd12);
    wait_cfg();
    tick();
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    check("hold_valid0", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 7; i++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_fields", 64'({rsp_tag, rsp_timeout, rsp_cycles}), 64'({4'd11, 1'b0, 12'd1}));
      check("hold_no_cfg", 64'(ctrl_config_en), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rel_drop",   64'(rsp_valid), 64'd0);
    check("rel_no_cfg", 64'(ctrl_config_en), 64'd0);
    tick();
    check("rel_cfg",    64'(ctrl_config_en), 64'd1);
    check("rel_fields", 64'({ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr}),
          64'({2'b11, 10'h222, 10'h333, 10'h3FF}));
    tick();
    ctrl_done = 1'b1;
    wait_rsp();
    check("rel_tag", 64'(rsp_tag), 64'd12);
    ctrl_done = 1'b0;
    ack();

    // Five consecutive pushes, sixth stalls on a full FIFO, in-order retire
    for (int i = 1; i <= 5; i++) begin
      check("burst_ready", 64'(cmd_ready), 64'd1);
      push(2'b00, 10'(i), 10'(i + 16), 10'(i + 32), 30'(i), 4'(i));
    end
    cmd_valid = 1'b1; cmd_tag = 4'd6;
    check("burst_full_count", 64'(fifo_count), 64'd4);
    check("burst_full_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    ctrl_done = 1'b1;
    wait_rsp();
    check("burst_tag1", 64'(rsp_tag), 64'd1);
    ack();
    push(2'b00, 10'd6, 10'd22, 10'd38, 30'd6, 4'd6);
    for (int t = 2; t <= 6; t++) begin
      wait_rsp();
      check("burst_tag", 64'(rsp_tag), 64'(t));
      ack();
    end
    ctrl_done = 1'b0;
    tick();

    // Reset in BUSY with two commands queued
    push(2'b10, 10'h100, 10'h101, 10'h102, 30'h7, 4'd13);
    push(2'b10, 10'h110, 10'h111, 10'h112, 30'h8, 4'd14);
    push(2'b10, 10'h120, 10'h121, 10'h122, 30'h9, 4'd15);
    check("pre_rst_busy",  64'(busy), 64'd1);
    check("pre_rst_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",   64'(busy), 64'd0);
    check("mid_rst_count",  64'(fifo_count), 64'd0);
    check("mid_rst_rsp",    64'(rsp_valid), 64'd0);
    check("mid_rst_cfg",    64'(ctrl_config_en), 64'd0);
    check("mid_rst_ready",  64'(cmd_ready), 64'd1);
    check("mid_rst_opcode", 64'(ctrl_opcode), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ctrl_done = (i % 3 == 0);
      tick();
      seen = seen | rsp_valid | ctrl_config_en;
    end
    ctrl_done = 1'b0;
    check("post_rst_quiet", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
